// File: rtl/da_pkg.sv
// Shared widths and state type for the distributed-arithmetic FIR MAC engine.
package da_pkg;

  localparam int DA_TAPS   = 4;
  localparam int DA_DATA_W = 8;
  localparam int DA_COEF_W = 8;
  localparam int DA_PS_W   = DA_COEF_W + $clog2(DA_TAPS);
  localparam int DA_ACC_W  = DA_DATA_W + DA_COEF_W + $clog2(DA_TAPS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } da_state_e;

endpackage

// File: rtl/da_engine_if.sv
// Control/FIFO-facing bundle of the DA engine: handshakes, coefficient load, tap window, result.
interface da_engine_if
  import da_pkg::*;
#(
  parameter int TAPS   = DA_TAPS,
  parameter int DATA_W = DA_DATA_W,
  parameter int COEF_W = DA_COEF_W,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
);

  logic                       reset_DA;
  logic                       CLOAD;
  logic signed [COEF_W-1:0]   coef_in;
  logic                       start_DA;
  logic [TAPS*DATA_W-1:0]     taps_in;
  logic signed [ACC_W-1:0]    y_out;
  logic                       valid_out;
  logic                       busy;

  modport master (
    output reset_DA, CLOAD, coef_in, start_DA, taps_in,
    input  y_out, valid_out, busy
  );

  modport slave (
    input  reset_DA, CLOAD, coef_in, start_DA, taps_in,
    output y_out, valid_out, busy
  );

endinterface

// File: rtl/da_partial_sum.sv
// Combinational DA partial sum: adds the sign-extended coefficients selected by the address bits.
module da_partial_sum
  import da_pkg::*;
#(
  parameter int TAPS   = DA_TAPS,
  parameter int COEF_W = DA_COEF_W,
  parameter int PS_W   = COEF_W + $clog2(TAPS)
) (
  input  logic [TAPS-1:0]         addr,
  input  logic [TAPS*COEF_W-1:0]  coefs,
  output logic signed [PS_W-1:0]  ps
);

  function automatic logic signed [PS_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
    return {{(PS_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  // Adder chain stands in for a 2^TAPS LUT, so a coefficient reload is usable immediately.
  always_comb begin
    ps = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (addr[k]) begin
        ps = ps + sext_coef(coefs[k*COEF_W +: COEF_W]);
      end
    end
  end

endmodule

// File: rtl/da_engine.sv
// Bit-serial distributed-arithmetic FIR MAC: one bit-plane per cycle, LSB first, sign plane subtracted.
module da_engine
  import da_pkg::*;
#(
  parameter int TAPS   = DA_TAPS,
  parameter int DATA_W = DA_DATA_W,
  parameter int COEF_W = DA_COEF_W,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic        clk,
  input  logic        resetn,
  da_engine_if.slave  bus
);

  localparam int PS_W  = COEF_W + $clog2(TAPS);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  da_state_e               state_q, state_d;
  logic                    do_load, do_start, do_bit, last_bit;
  logic [CNT_W-1:0]        bit_cnt;
  logic [TAPS*COEF_W-1:0]  coefs;
  logic [TAPS*DATA_W-1:0]  tap_sr;
  logic [TAPS-1:0]         addr;
  logic signed [PS_W-1:0]  ps_p0;
  logic signed [ACC_W-1:0] term_p0;
  logic signed [ACC_W-1:0] acc_next_p0;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [ACC_W-1:0] y_p1;
  logic                    vld_p1;

  function automatic logic signed [ACC_W-1:0] weigh(input logic signed [PS_W-1:0] p,
                                                    input logic [CNT_W-1:0]       b);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-PS_W){p[PS_W-1]}}, p};
    return ext <<< b;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || bus.reset_DA) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_start = 1'b0;
    do_bit   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CLOAD) begin
          do_load = 1'b1;
        end else if (bus.start_DA) begin
          do_start = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        do_bit = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          last_bit = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficients survive reset_DA; only the global reset clears them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      coefs <= '0;
    end else if (do_load && !bus.reset_DA) begin
      coefs <= {bus.coef_in, coefs[TAPS*COEF_W-1:COEF_W]};
    end
  end

  // Stage p0: current bit-plane address, partial sum, weighted term.
  always_comb begin
    addr = '0;
    for (int k = 0; k < TAPS; k++) begin
      addr[k] = tap_sr[k*DATA_W];
    end
  end

  da_partial_sum #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .PS_W   (PS_W)
  ) u_partial_sum (
    .addr  (addr),
    .coefs (coefs),
    .ps    (ps_p0)
  );

  assign term_p0     = weigh(ps_p0, bit_cnt);
  assign acc_next_p0 = last_bit ? (acc_p1 - term_p0) : (acc_p1 + term_p0);

  // Stage p1: accumulator, tap shifters, result register and valid pulse.
  always_ff @(posedge clk) begin
    if (!resetn || bus.reset_DA) begin
      bit_cnt <= '0;
      acc_p1  <= '0;
      tap_sr  <= '0;
      y_p1    <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (do_start) begin
        tap_sr  <= bus.taps_in;
        bit_cnt <= '0;
        acc_p1  <= '0;
      end else if (do_bit) begin
        for (int k = 0; k < TAPS; k++) begin
          tap_sr[k*DATA_W +: DATA_W] <= {1'b0, tap_sr[k*DATA_W+1 +: DATA_W-1]};
        end
        acc_p1 <= acc_next_p0;
        if (last_bit) begin
          bit_cnt <= '0;
          y_p1    <= acc_next_p0;
          vld_p1  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.y_out     = y_p1;
  assign bus.valid_out = vld_p1;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_da_engine.sv
// Bench for da_engine: vector table, multi-cycle corner sequences and randomized runs against a dot-product model.
module tb_da_engine;
  import da_pkg::*;

  localparam int TAPS   = DA_TAPS;
  localparam int DATA_W = DA_DATA_W;
  localparam int COEF_W = DA_COEF_W;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  da_engine_if bus ();

  da_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int c[TAPS];
    int x[TAPS];
    int y;
  } vec_t;

  vec_t vecs[6];
  int   model_c[TAPS];
  int   cv[TAPS];
  int   xv[TAPS];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_s();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic int model_y(input int x[TAPS]);
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += model_c[k] * x[k];
    return s;
  endfunction

  task automatic model_shift_in(input int c);
    for (int k = 0; k < TAPS - 1; k++) model_c[k] = model_c[k+1];
    model_c[TAPS-1] = c;
  endtask

  task automatic set_taps(input int x[TAPS]);
    logic [TAPS*DATA_W-1:0] tv;
    for (int k = 0; k < TAPS; k++) tv[k*DATA_W +: DATA_W] = DATA_W'(x[k]);
    bus.taps_in = tv;
  endtask

  task automatic load_coefs(input int c[TAPS]);
    bus.CLOAD = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      bus.coef_in = COEF_W'(c[i]);
      tick();
      model_shift_in(c[i]);
    end
    bus.CLOAD = 1'b0;
  endtask

  // Edge i counts posedges after the start edge; edge DATA_W is the final-bit edge.
  task automatic run(input string tag, input int x[TAPS], input int exp_y,
                     input int restart_a, input int restart_b,
                     input int cload_at, input int rstda_at);
    int     nvalid = 0;
    int     lat = -1;
    longint yv = 0;
    int     xr[TAPS];
    set_taps(x);
    bus.start_DA = 1'b1;
    tick();
    bus.start_DA = 1'b0;
    check({tag, " busy_after_start"}, bus.busy, 1);
    for (int i = 1; i <= DATA_W + 4; i++) begin
      bus.start_DA = (i == restart_a) || (i == restart_b);
      bus.CLOAD    = (i == cload_at);
      bus.reset_DA = (i == rstda_at);
      bus.coef_in  = COEF_W'($urandom);
      if (i == 2) begin
        for (int k = 0; k < TAPS; k++) xr[k] = rand_s();
        set_taps(xr);
      end
      tick();
      bus.start_DA = 1'b0;
      bus.CLOAD    = 1'b0;
      bus.reset_DA = 1'b0;
      if (bus.valid_out) begin
        nvalid++;
        if (lat < 0) begin
          lat = i;
          yv  = bus.y_out;
          check({tag, " busy_at_valid"}, bus.busy, 0);
        end
      end
    end
    if (rstda_at > 0) begin
      check({tag, " abort_valid_count"}, nvalid, 0);
      check({tag, " abort_y_cleared"}, bus.y_out, 0);
      check({tag, " abort_busy"}, bus.busy, 0);
    end else begin
      check({tag, " valid_count"}, nvalid, 1);
      check({tag, " latency"}, lat, DATA_W);
      check({tag, " y"}, yv, exp_y);
      check({tag, " y_held"}, bus.y_out, exp_y);
      check({tag, " busy_idle"}, bus.busy, 0);
    end
  endtask

  initial begin
    vecs[0].c = '{1, 2, 3, 4};          vecs[0].x = '{1, 1, 1, 1};              vecs[0].y = 10;
    vecs[1].c = '{1, 2, 3, 4};          vecs[1].x = '{-128, 0, 0, 0};           vecs[1].y = -128;
    vecs[2].c = '{1, 2, 3, 4};          vecs[2].x = '{5, -3, 0, 7};             vecs[2].y = 27;
    vecs[3].c = '{-128, -128, -128, -128}; vecs[3].x = '{-128, -128, -128, -128}; vecs[3].y = 65536;
    vecs[4].c = '{127, -128, 127, -128}; vecs[4].x = '{-128, 127, -128, 127};  vecs[4].y = -65024;
    vecs[5].c = '{100, -50, 25, -3};    vecs[5].x = '{-1, -1, -1, -1};          vecs[5].y = -72;

    bus.reset_DA = 1'b0;
    bus.CLOAD    = 1'b0;
    bus.start_DA = 1'b0;
    bus.coef_in  = '0;
    bus.taps_in  = '0;
    resetn       = 1'b0;
    for (int k = 0; k < TAPS; k++) model_c[k] = 0;
    tick();
    tick();
    resetn = 1'b1;
    check("por y_out", bus.y_out, 0);
    check("por valid_out", bus.valid_out, 0);
    check("por busy", bus.busy, 0);

    // Global reset must also wipe previously loaded coefficients.
    cv = '{5, 6, 7, 8};
    load_coefs(cv);
    xv = '{1, 1, 1, 1};
    run("pre_reset", xv, 26, -1, -1, -1, -1);
    resetn = 1'b0;
    tick();
    tick();
    for (int k = 0; k < TAPS; k++) model_c[k] = 0;
    check("rst y_out", bus.y_out, 0);
    check("rst valid_out", bus.valid_out, 0);
    check("rst busy", bus.busy, 0);
    resetn = 1'b1;
    for (int k = 0; k < TAPS; k++) xv[k] = rand_s();
    run("coefs_zeroed", xv, 0, -1, -1, -1, -1);

    for (int v = 0; v < 6; v++) begin
      load_coefs(vecs[v].c);
      run($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, -1, -1, -1, -1);
    end

    // Restart pulses mid-run and on the final-bit edge, plus a CLOAD while running.
    cv = '{1, 2, 3, 4};
    load_coefs(cv);
    xv = '{5, -3, 0, 7};
    run("restart_cload", xv, 27, 3, DATA_W, 5, -1);
    run("after_cload", xv, 27, -1, -1, -1, -1);

    xv = '{1, 1, 1, 1};
    run("abort", xv, 0, -1, -1, -1, 4);
    xv = '{2, -1, 3, 1};
    run("retained", xv, 2 - 2 + 9 + 4, -1, -1, -1, -1);

    // start_DA together with CLOAD loads a coefficient and does not start.
    bus.CLOAD    = 1'b1;
    bus.start_DA = 1'b1;
    bus.coef_in  = COEF_W'(9);
    tick();
    model_shift_in(9);
    bus.CLOAD    = 1'b0;
    bus.start_DA = 1'b0;
    check("start_with_cload busy", bus.busy, 0);
    tick();
    check("start_with_cload valid", bus.valid_out, 0);
    xv = '{1, 1, 1, 1};
    run("shifted_coefs", xv, 2 + 3 + 4 + 9, -1, -1, -1, -1);

    for (int r = 0; r < 20; r++) begin
      if (r == 0 || $urandom_range(2) == 0) begin
        for (int k = 0; k < TAPS; k++) cv[k] = rand_s();
        load_coefs(cv);
      end
      for (int k = 0; k < TAPS; k++) xv[k] = rand_s();
      run($sformatf("rand%0d", r), xv, model_y(xv), -1, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_engine.md
Name: da_engine

Overview:
- Distributed-arithmetic (DA) MAC stage directly downstream of the FIR Control block and the tap FIFO.
- Consumes the FIFO's parallel tap window, the Control handshakes start_DA/reset_DA, and the coefficient-load strobe CLOAD.
- Computes one FIR output as sum(coef[k]*x[k]) by bit-serial DA, LSB first, one input bit-plane per cycle.
- Reports the result with a one-cycle valid pulse that Control uses to drive global_valid_out.

Parameters:
- TAPS, 4, number of filter taps/coefficients.
- DATA_W, 8, signed two's-complement sample width = number of bit-serial iterations.
- COEF_W, 8, signed two's-complement coefficient width.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), signed accumulator/result width (18 at defaults).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- resetn  input  1  synchronous, active-low global reset.
- reset_DA  input  1  synchronous, active-high engine clear from Control.
- CLOAD  input  1  coefficient load strobe; one coefficient shifted in per cycle while high.
- coef_in  input  COEF_W  signed coefficient serial input.
- start_DA  input  1  start-of-computation pulse from Control.
- taps_in  input  TAPS*DATA_W  tap window from FIFO; x[k] = taps_in[k*DATA_W +: DATA_W], signed.
- y_out  output  ACC_W  signed filter result, held until the next result or clear.
- valid_out  output  1  one-cycle pulse: y_out updated this cycle.
- busy  output  1  high while in RUN.

Behaviour:
- Reset priority: resetn=0 > reset_DA=1 > CLOAD > start_DA.
- resetn=0 at a posedge:
  - state=IDLE; bit counter, accumulator, tap shift registers cleared.
  - All coef[k]=0, y_out=0, valid_out=0, busy=0.
- reset_DA=1 (resetn=1):
  - Same as resetn, except coefficients are retained.
  - Aborts any RUN in progress; no valid_out for the aborted computation.
- Coefficient load:
  - Each posedge with CLOAD=1 in IDLE: coef[k] <= coef[k+1] for k<TAPS-1, and coef[TAPS-1] <= coef_in.
  - After TAPS cycles, the first value loaded sits in coef[0].
  - CLOAD=1 in RUN: ignored, coefficients frozen.
- States: IDLE, RUN.
- IDLE -> RUN: posedge with start_DA=1 and CLOAD=0.
  - Latch taps_in into per-tap shift registers; counter b=0; acc=0; busy=1.
  - start_DA with CLOAD=1 is ignored.
- RUN, each posedge, b = 0..DATA_W-1:
  - Address bit k = current bit b of x[k].
  - ps = sum of sign-extended coef[k] over set address bits. ps is combinational, width COEF_W+$clog2(TAPS).
  - acc <= acc + (ps <<< b) when b<DATA_W-1; acc <= acc - (ps <<< b) when b=DATA_W-1 (sign-bit weight).
  - Arithmetic is signed in ACC_W; overflow is impossible by construction.
- Final bit (b=DATA_W-1):
  - y_out <= final acc value; valid_out=1 for exactly that cycle.
  - state -> IDLE; busy=0.
- Latency: valid_out rises DATA_W cycles after the start_DA edge (8 at defaults).
- Throughput: one result per DATA_W+1 cycles.
- start_DA in RUN, including the final-bit cycle: ignored, no queueing.
- taps_in changes during RUN: no effect; samples are latched at start.
- valid_out is 0 in every cycle other than the final-bit cycle.

Decomposition:
- Package da_pkg holds:
  - Default widths TAPS/DATA_W/COEF_W and the derived ACC_W and PS_W.
  - The state enum {IDLE, RUN}.
- Sub-module da_partial_sum: combinational TAPS-input signed adder.
  - Inputs: address bits and coefficient vector.
  - Output: ps.
  - Replaces a stored 2^TAPS LUT, so CLOAD needs no LUT-rebuild phase.

Test Plan:
- Reset: resetn=0 for 2 cycles with prior nonzero coefs -> y_out=0, valid_out=0, busy=0, coefficients read back 0 via a result of 0 for any taps.
- Load coef 1,2,3,4 (CLOAD 4 cycles); taps all 1; start_DA -> exactly 8 cycles later valid_out=1 for 1 cycle, y_out=10, busy low afterwards.
- Same coefs; taps x0=-128, x1..x3=0 -> y_out=-128. Then x=(5,-3,0,7) -> y_out=5-6+0+28=27.
- Coefs all -128, taps all -128 -> y_out=65536 (0x10000, no overflow at ACC_W=18).
- start_DA pulsed again at cycle 3 of RUN and on the final-bit cycle -> ignored, single valid_out. CLOAD during RUN -> coefficients unchanged, next result identical.
- reset_DA asserted at cycle 4 of RUN -> no valid_out, y_out=0, state IDLE. A new start gives the correct result using the retained coefficients.
